// File: rtl/alu_res_station.sv
// Four-entry ALU reservation station: one-hot write, CDB wakeup with write-cycle
// bypass, fixed-priority (lowest index) issue into a registered issue bundle.
module alu_res_station #(
    parameter int WIDTH = 31,
    parameter int ALU   = 3,
    parameter int ROB   = 2,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ALU:0]     ALURequests,
    input  logic [OPW:0]     wrOp,
    input  logic [WIDTH:0]   wrSrc1,
    input  logic [WIDTH:0]   wrSrc2,
    input  logic [ROB:0]     wrTag1,
    input  logic [ROB:0]     wrTag2,
    input  logic             wrRdy1,
    input  logic             wrRdy2,
    input  logic [ROB:0]     wrRobTag,
    input  logic             cdbValid,
    input  logic [ROB:0]     cdbTag,
    input  logic [WIDTH:0]   cdbResult,
    input  logic             fuReady,
    input  logic             flush,
    output logic [ALU:0]     ALUBusyVector,
    output logic             issueValid,
    output logic [OPW:0]     issueOp,
    output logic [WIDTH:0]   issueSrc1,
    output logic [WIDTH:0]   issueSrc2,
    output logic [ROB:0]     issueRobTag
);

    localparam int SELW = (ALU > 0) ? $clog2(ALU + 1) : 1;

    logic [ALU:0]   r_busy;
    logic [ALU:0]   r_rdy1;
    logic [ALU:0]   r_rdy2;
    logic [OPW:0]   r_op     [0:ALU];
    logic [WIDTH:0] r_src1   [0:ALU];
    logic [WIDTH:0] r_src2   [0:ALU];
    logic [ROB:0]   r_tag1   [0:ALU];
    logic [ROB:0]   r_tag2   [0:ALU];
    logic [ROB:0]   r_robTag [0:ALU];

    logic           r_issueValid;
    logic [OPW:0]   r_issueOp;
    logic [WIDTH:0] r_issueSrc1;
    logic [WIDTH:0] r_issueSrc2;
    logic [ROB:0]   r_issueRobTag;

    logic [ALU:0]    w_wrEn;
    logic [ALU:0]    w_elig;
    logic            w_any;
    logic [SELW-1:0] w_sel;
    logic            w_byp1;
    logic            w_byp2;

    assign w_wrEn = ALURequests & ~r_busy;
    assign w_elig = r_busy & r_rdy1 & r_rdy2;
    // Operand produced on the CDB in the same cycle it is written
    assign w_byp1 = ~wrRdy1 & cdbValid & (wrTag1 == cdbTag);
    assign w_byp2 = ~wrRdy2 & cdbValid & (wrTag2 == cdbTag);

    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int unsigned i = 0; i < ALU + 1; i++) begin
            if (w_elig[i] && !w_any) begin
                w_any = 1'b1;
                w_sel = SELW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy        <= '0;
            r_rdy1        <= '0;
            r_rdy2        <= '0;
            r_issueValid  <= 1'b0;
            r_issueOp     <= '0;
            r_issueSrc1   <= '0;
            r_issueSrc2   <= '0;
            r_issueRobTag <= '0;
            for (int unsigned i = 0; i < ALU + 1; i++) begin
                r_op[i]     <= '0;
                r_src1[i]   <= '0;
                r_src2[i]   <= '0;
                r_tag1[i]   <= '0;
                r_tag2[i]   <= '0;
                r_robTag[i] <= '0;
            end
        end else if (flush) begin
            r_busy       <= '0;
            r_issueValid <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < ALU + 1; i++) begin
                if (w_wrEn[i]) begin
                    r_busy[i]   <= 1'b1;
                    r_op[i]     <= wrOp;
                    r_tag1[i]   <= wrTag1;
                    r_tag2[i]   <= wrTag2;
                    r_robTag[i] <= wrRobTag;
                    r_rdy1[i]   <= wrRdy1 | w_byp1;
                    r_rdy2[i]   <= wrRdy2 | w_byp2;
                    r_src1[i]   <= w_byp1 ? cdbResult : wrSrc1;
                    r_src2[i]   <= w_byp2 ? cdbResult : wrSrc2;
                end else if (r_busy[i]) begin
                    if (!r_rdy1[i] && cdbValid && (r_tag1[i] == cdbTag)) begin
                        r_src1[i] <= cdbResult;
                        r_rdy1[i] <= 1'b1;
                    end
                    if (!r_rdy2[i] && cdbValid && (r_tag2[i] == cdbTag)) begin
                        r_src2[i] <= cdbResult;
                        r_rdy2[i] <= 1'b1;
                    end
                end
            end
            // Write targets only idle entries and issue only busy ones, so the
            // busy-bit updates below never collide with the write above.
            if (fuReady && w_any) begin
                r_issueValid  <= 1'b1;
                r_issueOp     <= r_op[w_sel];
                r_issueSrc1   <= r_src1[w_sel];
                r_issueSrc2   <= r_src2[w_sel];
                r_issueRobTag <= r_robTag[w_sel];
                r_busy[w_sel] <= 1'b0;
            end else begin
                r_issueValid <= 1'b0;
            end
        end
    end

    assign ALUBusyVector = r_busy;
    assign issueValid    = r_issueValid;
    assign issueOp       = r_issueOp;
    assign issueSrc1     = r_issueSrc1;
    assign issueSrc2     = r_issueSrc2;
    assign issueRobTag   = r_issueRobTag;

endmodule

// File: doc/alu_res_station.md
ALU_RES_STATION -- requirements
Module: alu_res_station

Interface
- REQ-001 Parameter WIDTH, default 31, operand/result MSB index (data [WIDTH:0]).
- REQ-002 Parameter ALU, default 3, entry-index MSB (ALU+1 = 4 entries).
- REQ-003 Parameter ROB, default 2, ROB tag MSB index (tag [ROB:0]).
- REQ-004 Parameter OPW, default 3, ALU opcode MSB index.
- REQ-005 clk  input  1  single clock, all state rising-edge.
- REQ-006 reset  input  1  asynchronous, active-high.
- REQ-007 ALURequests  input  [ALU:0]  one-hot write select from arbiter; all-zero = no write.
- REQ-008 wrOp  input  [OPW:0]  opcode of instruction being written.
- REQ-009 wrSrc1, wrSrc2  input  [WIDTH:0] each  operand values, meaningful when matching ready bit is high.
- REQ-010 wrTag1, wrTag2  input  [ROB:0] each  producer ROB tags for operands not ready.
- REQ-011 wrRdy1, wrRdy2  input  1 each  operand already available.
- REQ-012 wrRobTag  input  [ROB:0]  destination ROB tag.
- REQ-013 cdbValid  input  1  common data bus broadcast valid.
- REQ-014 cdbTag  input  [ROB:0]; cdbResult  input  [WIDTH:0]  broadcast tag/value.
- REQ-015 fuReady  input  1  ALU can accept an instruction at the next edge.
- REQ-016 flush  input  1  synchronous squash of all entries.
- REQ-017 ALUBusyVector  output  [ALU:0]  registered per-entry busy, fed back to arbiter.
- REQ-018 issueValid  output  1; issueOp [OPW:0]; issueSrc1, issueSrc2 [WIDTH:0]; issueRobTag [ROB:0]  registered issue bundle.

Function
- REQ-019 Per entry state: busy, op, src1/src2, tag1/tag2, rdy1/rdy2, robTag.
- REQ-020 Write: at edge, entry i with ALURequests[i]=1 and busy[i]=0 loads all wr* fields, busy[i]<=1.
- REQ-021 ALURequests to an already-busy entry shall be ignored; entry unchanged (bench asserts never occurs).
- REQ-022 ALURequests with more than one bit set shall be treated as a protocol violation; bench asserts never occurs.
- REQ-023 Wakeup: for each busy entry with rdyK=0 and cdbValid=1 and tagK==cdbTag, at edge srcK<=cdbResult, rdyK<=1; both operands may wake in same cycle.
- REQ-024 Write-cycle bypass: if wrRdyK=0 and cdbValid=1 and wrTagK==cdbTag, the written entry captures cdbResult with rdyK=1.
- REQ-025 Eligible(i) = busy[i] & rdy1[i] & rdy2[i], evaluated on registered state only.
- REQ-026 Select: lowest eligible index wins (fixed priority, entry 0 highest).
- REQ-027 Issue: at edge, if fuReady=1 and any entry eligible, winner's fields load issue bundle, issueValid<=1, winner busy<=0.
- REQ-028 Otherwise issueValid<=0 at edge; issue data outputs hold previous values.
- REQ-029 Latency: write at edge N -> earliest issueValid at edge N+1 (both operands ready on write); CDB wakeup at edge N -> earliest issue at edge N+1.
- REQ-030 An entry freed by issue at edge N shows ALUBusyVector[i]=0 after edge N and may be rewritten at edge N+1.
- REQ-031 At most one issue per cycle; at most one write per cycle; write and issue in same cycle shall proceed independently (different entries by construction).
- REQ-032 Full (all 4 busy): no write accepted; issue still proceeds; no stall output generated (fullness signalled by arbiter).
- REQ-033 Flush: at edge, all busy<=0 and issueValid<=0; flush overrides write, wakeup and issue in that cycle.
- REQ-034 ALUBusyVector equals busy register contents directly, no combinational path from inputs.

Reset
- REQ-035 reset=1 asynchronously forces all busy=0, all rdy=0, issueValid=0, issue data/tag outputs=0, ALUBusyVector=0.
- REQ-036 Reset asserted mid-operation discards all entries and any in-flight issue; first write accepted at first edge after deassertion.

Verification
- REQ-037 Write entry0 (rdy1=rdy2=1, src1=5, src2=7, robTag=3), fuReady=1 -> next edge issueValid=1, issueSrc1=5, issueSrc2=7, issueRobTag=3; ALUBusyVector 0001 then 0000.
- REQ-038 Write entry1 with rdy2=0, tag2=6; later cdbValid=1, cdbTag=6, cdbResult=0x55 -> issue following edge with issueSrc2=0x55.
- REQ-039 Write with wrRdy1=0, wrTag1=2 while cdbValid=1, cdbTag=2, cdbResult=9 -> entry issues next edge with issueSrc1=9.
- REQ-040 Fill all 4 entries ready, fuReady=1 -> issue order entries 0,1,2,3 on consecutive edges; ALUBusyVector 1111,1110,1100,1000,0000.
- REQ-041 Entries 0 and 2 ready, fuReady=0 for 3 cycles -> issueValid=0, busy held; fuReady=1 -> entry0 issues first.
- REQ-042 Flush with 3 busy entries and simultaneous write -> ALUBusyVector=0000, issueValid=0 next edge; async reset mid-run -> all outputs 0 immediately.
